multi_fifo_status_ctrl: RTL and testbench
=========================================

# multi_fifo_status_ctrl

Multi-channel FIFO-status request controller. It watches the fill level of NCH line FIFOs, each feeding or draining one video channel. It raises burst or tail requests to a single shared AXI VDMA address/data engine, arbitrating round-robin between channels. Each channel has its own frame-sync address-reset hold-off. On frame sync it drains an accepted burst instead of dropping it.

## Interface
- NCH, 2, number of channels (1..8)
- CSIZE, 10, width of each FIFO count
- FULL_LEN, 256, FIFO depth in words
- THRESHOLD, 200, empty/fill threshold
- BURST_LEN, 100, normal burst length
- LSIZE, 9, request length width
- WR_RD, "READ", "READ" or "WRITE" trigger mode
- RST_WAIT, 31, cycles of fsync low a channel must see before leaving address reset
- clock  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  NCH  per-channel enable
- count  in  NCH*CSIZE  per-channel FIFO count; channel i is bits [i*CSIZE +: CSIZE]
- fsync  in  NCH  per-channel frame sync, level
- tail_status  in  NCH  next request of channel i is the line tail
- tail_len  in  NCH*LSIZE  per-channel tail length
- req  out  1  request valid to DMA engine
- req_tail  out  1  current request is a tail
- req_ch  out  CHW=max(1,$clog2(NCH))  granted channel index
- req_len  out  LSIZE  request length
- resp  in  1  DMA accepted request
- done  in  1  DMA finished request
- burst_done  out  NCH  one-cycle pulse per channel
- tail_done  out  NCH  one-cycle pulse per channel
- in_reset  out  NCH  channel i is holding in address reset

## Operation
- Trigger, registered per channel, compared unsigned at 32 bits:
  - READ: trig[i] = enable[i] && (FULL_LEN-THRESHOLD) > count[i]
  - WRITE: trig[i] = enable[i] && count[i] > THRESHOLD
- Channel state is READY or RST_HOLD.
  - fsync[i] high forces RST_HOLD and clears counter rcnt[i].
  - In RST_HOLD, rcnt increments each cycle fsync[i] is low.
  - When rcnt > RST_WAIT, the channel returns to READY.
  - in_reset[i] = (state == RST_HOLD).
- Eligibility: elig[i] = READY && !fsync[i] && trig[i].
- Engine FSM has four states: IDLE, REQ, WAIT_DONE, FINISH.
- IDLE → REQ when any channel is eligible.
  - The round-robin winner is chosen starting after the last granted channel.
  - The winner's index, tail_status and length are latched: BURST_LEN, or tail_len when tail_status.
- REQ: req = 1; all req_* outputs stay stable.
  - On resp → WAIT_DONE.
  - On fsync[req_ch] without resp → IDLE; no done pulse; the arbiter pointer does not advance.
- WAIT_DONE: an abort flag is set if fsync[req_ch] rises here, or on the resp cycle.
  - On done → FINISH if no abort; → IDLE if aborted, with no done pulse.
- FINISH: burst_done[req_ch] or tail_done[req_ch] pulses; the pointer advances; → IDLE.
- fsync on a non-granted channel never disturbs the engine.
- No simulation-only delays anywhere.

## Timing
- Reset values: req, req_tail, req_ch, req_len, burst_done, tail_done all 0; in_reset all 0; channels READY; engine IDLE; pointer 0.
- count to trig: 1 cycle. trig to req high: 1 cycle, with IDLE state registered.
- req drops the cycle after resp is sampled. The done pulse is high the cycle after done is sampled.
- Minimum request period is 4 cycles: REQ, WAIT_DONE, FINISH, IDLE.
- Simultaneous events:
  - resp and fsync[req_ch] in the same cycle → WAIT_DONE with abort set.
  - done and fsync[req_ch] in the same cycle → aborted, no pulse.
- fsync held high keeps rcnt at 0. The RST_HOLD exit is registered, so the channel is eligible RST_WAIT+2 cycles after fsync falls.
- Reset asserted mid-request: all outputs clear immediately, asynchronously.
- rcnt width is $clog2(RST_WAIT+2); no wrap occurs because the channel exits first.

## Structure
- SystemPkg holds the engine state enum (IDLE, REQ, WAIT_DONE, FINISH) and the channel state enum (READY, RST_HOLD).
- Sub-module rr_arbiter, parameter NCH.
  - Inputs: request vector, advance strobe.
  - Outputs: grant index, grant valid.
  - The pointer updates only on advance.

## Test plan
- NCH=2, READ mode, count0=10, count1=100, enable=2'b11 → req, req_ch=0, req_len=100. resp then done → burst_done[0] pulse exactly 1 cycle; channel 1 is never granted.
- Both counts 10 with repeated resp/done → req_ch alternates 0,1,0,1.
- tail_status[1]=1, tail_len[1]=37 → req_tail=1, req_len=37, and tail_done[1] pulses instead of burst_done.
- fsync[0] pulses 1 cycle during REQ ch0 → req drops next cycle with no done pulse. in_reset[0] stays high for RST_WAIT+2 cycles, then ch0 is re-requested.
- fsync[0] during WAIT_DONE → req stays low; done arrives 20 cycles later with no pulse; the engine returns to IDLE and serves ch1 meanwhile-eligible.
- WRITE mode, count=201 → trigger; count=200 → no request. rst_n low mid-WAIT_DONE → all outputs 0 asynchronously.

Source files
------------

// File: rtl/multi_fifo_status_ctrl_pkg.sv
// SystemPkg: engine and channel state encodings for multi_fifo_status_ctrl
package SystemPkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE, FINISH} eng_state_t;
  typedef enum logic {READY, RST_HOLD} ch_state_t;
endpackage

// File: rtl/multi_fifo_status_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin grant searching from the pointer; pointer moves past the grant on advance
module rr_arbiter #(
  parameter int NCH = 2,
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic           clock,
  input  logic           rst_n,
  input  logic [NCH-1:0] request,
  input  logic           advance,
  output logic [CHW-1:0] grant,
  output logic           valid
);
  logic [CHW-1:0] ptr;
  always_comb begin
    grant = '0;
    valid = |request;
    for (int k = NCH - 1; k >= 0; k--)
      if (request[(int'(ptr) + k) % NCH]) grant = CHW'((int'(ptr) + k) % NCH);
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (advance) ptr <= CHW'((int'(grant) + 1) % NCH);
endmodule

// File: rtl/multi_fifo_status_ctrl.sv
// multi_fifo_status_ctrl: round-robin FIFO-level burst/tail requester for a shared VDMA engine
module multi_fifo_status_ctrl
  import SystemPkg::*;
#(
  parameter int NCH       = 2,
  parameter int CSIZE     = 10,
  parameter int FULL_LEN  = 256,
  parameter int THRESHOLD = 200,
  parameter int BURST_LEN = 100,
  parameter int LSIZE     = 9,
  parameter     WR_RD     = "READ",
  parameter int RST_WAIT  = 31,
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       enable,
  input  logic [NCH*CSIZE-1:0] count,
  input  logic [NCH-1:0]       fsync,
  input  logic [NCH-1:0]       tail_status,
  input  logic [NCH*LSIZE-1:0] tail_len,
  output logic                 req,
  output logic                 req_tail,
  output logic [CHW-1:0]       req_ch,
  output logic [LSIZE-1:0]     req_len,
  input  logic                 resp,
  input  logic                 done,
  output logic [NCH-1:0]       burst_done,
  output logic [NCH-1:0]       tail_done,
  output logic [NCH-1:0]       in_reset
);
  localparam int RW = $clog2(RST_WAIT + 2);
  localparam bit RD = WR_RD == "READ";
  logic [NCH-1:0] trig, elig, oh;
  ch_state_t      cst [NCH];
  logic [RW-1:0]  rcnt [NCH];
  eng_state_t     state, nxt;
  logic           abort, abort_nxt, valid, hit;
  logic [CHW-1:0] grant;
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      trig <= '0;
      for (int i = 0; i < NCH; i++) begin
        cst[i]  <= READY;
        rcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        trig[i] <= enable[i] && (RD ? 32'(FULL_LEN - THRESHOLD) > 32'(count[i*CSIZE +: CSIZE])
                                    : 32'(count[i*CSIZE +: CSIZE]) > 32'(THRESHOLD));
        if (fsync[i]) begin
          cst[i]  <= RST_HOLD;
          rcnt[i] <= '0;
        end else if (cst[i] == RST_HOLD) begin
          if (32'(rcnt[i]) > 32'(RST_WAIT)) cst[i] <= READY;
          else rcnt[i] <= rcnt[i] + 1'b1;
        end
      end
    end
  always_comb begin
    in_reset = '0;
    for (int i = 0; i < NCH; i++) in_reset[i] = cst[i] == RST_HOLD;
  end
  assign elig = ~in_reset & ~fsync & trig;
  assign hit  = fsync[req_ch];
  assign oh   = NCH'(1) << req_ch;
  // Outside IDLE the arbiter only sees the granted channel, so advance steps past req_ch.
  rr_arbiter #(.NCH(NCH)) u_arb (
    .clock  (clock),
    .rst_n  (rst_n),
    .request(state == IDLE ? elig : oh),
    .advance(state == FINISH),
    .grant  (grant),
    .valid  (valid)
  );
  always_comb begin
    nxt       = state;
    abort_nxt = abort;
    case (state)
      IDLE: if (valid) begin
        nxt       = REQ;
        abort_nxt = 1'b0;
      end
      REQ: if (resp) begin
        nxt       = WAIT_DONE;
        abort_nxt = hit;
      end else if (hit) nxt = IDLE;
      WAIT_DONE: begin
        abort_nxt = abort | hit;
        if (done) nxt = abort_nxt ? IDLE : FINISH;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      abort    <= 1'b0;
      req_ch   <= '0;
      req_tail <= 1'b0;
      req_len  <= '0;
    end else begin
      state <= nxt;
      abort <= abort_nxt;
      if (state == IDLE && valid) begin
        req_ch   <= grant;
        req_tail <= tail_status[grant];
        req_len  <= tail_status[grant] ? tail_len[int'(grant)*LSIZE +: LSIZE] : LSIZE'(BURST_LEN);
      end
    end
  assign req        = state == REQ;
  assign burst_done = (state == FINISH && !req_tail) ? oh : '0;
  assign tail_done  = (state == FINISH && req_tail) ? oh : '0;
endmodule

// File: tb/tb_multi_fifo_status_ctrl.sv
// tb_multi_fifo_status_ctrl: scoreboard bench for the READ and WRITE configurations
module tb_multi_fifo_status_ctrl;
  localparam int NCH = 2;
  localparam int RST_WAIT = 31;
  logic clock = 0, rst_n = 0, rst_w_n = 0;
  logic [1:0] enable = 0, fsync = 0, tail_status = 0, burst_done, tail_done, in_reset;
  logic [19:0] count = 0;
  logic [17:0] tail_len = 0;
  logic req, req_tail, resp = 0, done = 0;
  logic [0:0] req_ch;
  logic [8:0] req_len;
  logic [1:0] enable_w = 0, fsync_w = 0, tail_status_w = 0, burst_done_w, tail_done_w, in_reset_w;
  logic [19:0] count_w = 0;
  logic [17:0] tail_len_w = 0;
  logic req_w, req_tail_w, resp_w = 0, done_w = 0;
  logic [0:0] req_ch_w;
  logic [8:0] req_len_w;
  typedef struct {int ch; bit tail; int len;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, mptr = 0;

  always #5 clock = ~clock;

  multi_fifo_status_ctrl #(.NCH(NCH), .WR_RD("READ"), .RST_WAIT(RST_WAIT)) dut (
    .clock(clock), .rst_n(rst_n), .enable(enable), .count(count), .fsync(fsync),
    .tail_status(tail_status), .tail_len(tail_len), .req(req), .req_tail(req_tail),
    .req_ch(req_ch), .req_len(req_len), .resp(resp), .done(done),
    .burst_done(burst_done), .tail_done(tail_done), .in_reset(in_reset));

  multi_fifo_status_ctrl #(.NCH(NCH), .WR_RD("WRITE"), .RST_WAIT(RST_WAIT)) dut_w (
    .clock(clock), .rst_n(rst_w_n), .enable(enable_w), .count(count_w), .fsync(fsync_w),
    .tail_status(tail_status_w), .tail_len(tail_len_w), .req(req_w), .req_tail(req_tail_w),
    .req_ch(req_ch_w), .req_len(req_len_w), .resp(resp_w), .done(done_w),
    .burst_done(burst_done_w), .tail_done(tail_done_w), .in_reset(in_reset_w));

  task automatic tick(int n = 1);
    repeat (n) @(negedge clock);
  endtask

  function automatic int winner(logic [1:0] m);
    for (int k = 0; k < NCH; k++)
      if (m[(mptr + k) % NCH]) return (mptr + k) % NCH;
    return 0;
  endfunction

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      tick();
      ok = req;
    end
  endtask

  task automatic push(logic [1:0] m);
    int w;
    w = winner(m);
    sb.push_back('{w, tail_status[w], tail_status[w] ? int'(tail_len[w*9 +: 9]) : 100});
  endtask

  task automatic serve(logic [1:0] en_after);
    exp_t e;
    bit ok;
    logic [1:0] oh;
    wait_req(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("FAIL serve_req: req=%b queued=%0d, required req=1 with an expected entry", req, sb.size());
      return;
    end
    e = sb.pop_front();
    oh = 2'(1 << e.ch);
    if ({req_tail, req_ch, req_len} !== {e.tail, 1'(e.ch), 9'(e.len)}) begin
      errors++;
      $display("FAIL grant: ch=%0d tail=%0b len=%0d, required ch=%0d tail=%0b len=%0d",
               req_ch, req_tail, req_len, e.ch, e.tail, e.len);
    end
    enable = en_after;
    tick();
    checks++;
    if ({req, req_tail, req_ch, req_len} !== {1'b1, e.tail, 1'(e.ch), 9'(e.len)}) begin
      errors++;
      $display("FAIL req_stable: req=%b ch=%0d len=%0d, required req=1 ch=%0d len=%0d", req, req_ch, req_len, e.ch, e.len);
    end
    resp = 1;
    tick();
    resp = 0;
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL req_drop: req=%b, required 0", req);
    end
    tick(2);
    done = 1;
    tick();
    done = 0;
    checks++;
    if (burst_done !== (e.tail ? 2'b00 : oh) || tail_done !== (e.tail ? oh : 2'b00)) begin
      errors++;
      $display("FAIL done_pulse: burst_done=%b tail_done=%b, required %b %b",
               burst_done, tail_done, e.tail ? 2'b00 : oh, e.tail ? oh : 2'b00);
    end
    tick();
    checks++;
    if ({burst_done, tail_done} !== 4'b0) begin
      errors++;
      $display("FAIL pulse_width: burst_done=%b tail_done=%b, required 00 00", burst_done, tail_done);
    end
    mptr = (e.ch + 1) % NCH;
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if ({req, req_tail, req_ch, req_len, burst_done, tail_done, in_reset} !== '0) begin
      errors++;
      $display("FAIL reset_held: outputs=%h, required 0", {req, req_tail, req_ch, req_len, burst_done, tail_done, in_reset});
    end
    rst_n = 1;
    rst_w_n = 1;
    tick(3);
    checks++;
    if ({req, req_tail, req_ch, req_len, burst_done, tail_done, in_reset} !== '0) begin
      errors++;
      $display("FAIL reset_release: outputs=%h, required 0", {req, req_tail, req_ch, req_len, burst_done, tail_done, in_reset});
    end
  endtask

  task automatic test_burst();
    int hits = 0;
    count = {10'd100, 10'd10};
    enable = 2'b11;
    push(2'b01);
    serve(2'b10);
    repeat (15) begin
      tick();
      hits += int'(req);
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL ch1_not_triggered: req high %0d cycles, required 0", hits);
    end
  endtask

  task automatic test_back_to_back();
    count = {10'd10, 10'd10};
    enable = 2'b11;
    for (int k = 0; k < 4; k++) begin
      push(2'b11);
      serve(k == 3 ? 2'b00 : 2'b11);
    end
  endtask

  task automatic test_tail();
    tail_status = 2'b10;
    tail_len = {9'd37, 9'd0};
    enable = 2'b10;
    push(2'b10);
    serve(2'b00);
    tail_status = 2'b00;
  endtask

  task automatic test_fsync_req();
    exp_t e;
    bit ok, bad = 0;
    int n = 0;
    enable = 2'b01;
    push(2'b01);
    e = sb.pop_front();
    wait_req(ok);
    checks++;
    if (!ok || req_ch !== 1'(e.ch)) begin
      errors++;
      $display("FAIL fsync_req_grant: req=%b ch=%0d, required 1 %0d", req, req_ch, e.ch);
    end
    fsync = 2'b01;
    tick();
    fsync = 2'b00;
    checks++;
    if (req !== 1'b0 || in_reset !== 2'b01) begin
      errors++;
      $display("FAIL fsync_req_abort: req=%b in_reset=%b, required 0 01", req, in_reset);
    end
    while (in_reset[0] && n < 100) begin
      n++;
      bad |= req | (|burst_done) | (|tail_done);
      tick();
    end
    checks++;
    if (n != RST_WAIT + 2 || bad) begin
      errors++;
      $display("FAIL rst_hold_len: in_reset cycles=%0d activity=%b, required %0d 0", n, bad, RST_WAIT + 2);
    end
    push(2'b01);
    serve(2'b00);
  endtask

  task automatic test_fsync_wait();
    exp_t e;
    bit ok, bad = 0;
    count = {10'd10, 10'd10};
    enable = 2'b01;
    push(2'b01);
    e = sb.pop_front();
    wait_req(ok);
    checks++;
    if (!ok || req_ch !== 1'(e.ch)) begin
      errors++;
      $display("FAIL fsync_wait_grant: req=%b ch=%0d, required 1 %0d", req, req_ch, e.ch);
    end
    resp = 1;
    tick();
    resp = 0;
    enable = 2'b11;
    fsync = 2'b01;
    tick();
    fsync = 2'b00;
    repeat (20) begin
      bad |= req | (|burst_done) | (|tail_done);
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL wait_done_hold: req or pulse seen=%b, required 0", bad);
    end
    done = 1;
    tick();
    done = 0;
    checks++;
    if ({req, burst_done, tail_done} !== 5'b0) begin
      errors++;
      $display("FAIL aborted_done: req=%b burst_done=%b tail_done=%b, required all 0", req, burst_done, tail_done);
    end
    push(2'b10);
    serve(2'b00);
  endtask

  task automatic test_resp_fsync();
    exp_t e;
    bit ok;
    tick(40);
    enable = 2'b01;
    push(2'b01);
    e = sb.pop_front();
    wait_req(ok);
    checks++;
    if (!ok || req_ch !== 1'(e.ch)) begin
      errors++;
      $display("FAIL simul_grant: req=%b ch=%0d, required 1 %0d", req, req_ch, e.ch);
    end
    resp = 1;
    fsync = 2'b01;
    tick();
    resp = 0;
    fsync = 2'b00;
    enable = 2'b00;
    tick(3);
    done = 1;
    tick();
    done = 0;
    checks++;
    if ({req, burst_done, tail_done} !== 5'b0) begin
      errors++;
      $display("FAIL simul_abort: req=%b burst_done=%b tail_done=%b, required all 0", req, burst_done, tail_done);
    end
  endtask

  task automatic test_write();
    bit ok = 0;
    int hits = 0;
    enable_w = 2'b01;
    count_w = {10'd0, 10'd201};
    for (int n = 0; n < 40 && !ok; n++) begin
      tick();
      ok = req_w;
    end
    checks++;
    if (!ok || req_ch_w !== 1'b0 || req_len_w !== 9'd100) begin
      errors++;
      $display("FAIL write_trigger: req=%b ch=%0d len=%0d, required 1 0 100", req_w, req_ch_w, req_len_w);
    end
    resp_w = 1;
    tick();
    resp_w = 0;
    tick();
    #2 rst_w_n = 0;
    #1;
    checks++;
    if ({req_w, req_tail_w, req_ch_w, req_len_w, burst_done_w, tail_done_w, in_reset_w} !== '0) begin
      errors++;
      $display("FAIL async_reset: req=%b len=%0d pulses=%b%b in_reset=%b, required all 0",
               req_w, req_len_w, burst_done_w, tail_done_w, in_reset_w);
    end
    count_w = {10'd0, 10'd200};
    tick();
    rst_w_n = 1;
    repeat (20) begin
      tick();
      hits += int'(req_w);
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL write_threshold: req high %0d cycles at count 200, required 0", hits);
    end
    enable_w = 2'b00;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_back_to_back();
    test_tail();
    test_fsync_req();
    test_fsync_wait();
    test_resp_fsync();
    test_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
